// File: rtl/i2c_uart_host_if.sv
// Command/response bundle between a host-side requester and the i2c_uart_host
// I2C master. The requester uses the master modport, the I2C master the slave one.
interface i2c_uart_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rnw;
    logic [7:0] cmd_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       nack;

    modport master (
        output cmd_valid, cmd_rnw, cmd_data,
        input  cmd_ready, rx_data, rx_valid, nack
    );

    modport slave (
        input  cmd_valid, cmd_rnw, cmd_data,
        output cmd_ready, rx_data, rx_valid, nack
    );
endinterface

// File: rtl/i2c_uart_host.sv
// Single-byte I2C master for the SoC's i2c "uart" link. Each accepted command
// runs START, address+rnw, ack, one data byte, ack, STOP on open-drain pads.
module i2c_uart_host #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic               clk,
    input  logic               res,
    i2c_uart_host_if.slave     cmd,
    output logic               scl_oe,
    output logic               sda_oe,
    input  logic               scl_i,
    input  logic               sda_i
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // Stretch is judged once the released SCL has had two cycles to reach the
    // synchroniser output, so an unstretched quarter keeps its nominal length.
    localparam logic [DIV_W-1:0] HOLD_AT  = DIV_W'((CLK_DIV > 2) ? 2 : (CLK_DIV - 1));

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DACK     = 3'd5,
        S_STOP     = 3'd6
    } state_t;

    state_t           state_r, nxt_state_s;
    logic [DIV_W-1:0] div_r, nxt_div_s;
    logic [1:0]       q_r, nxt_q_s;
    logic [2:0]       bit_r, nxt_bit_s;
    logic [7:0]       shift_r, nxt_shift_s;
    logic             rnw_r, nxt_rnw_s;
    logic [7:0]       data_r, nxt_data_s;
    logic [7:0]       rx_data_r, nxt_rx_data_s;
    logic             rx_valid_r, nxt_rx_valid_s;
    logic             nack_r, nxt_nack_s;
    logic             ready_r, nxt_ready_s;
    logic             scl_oe_r, sda_oe_r;
    logic [1:0]       pad_s;
    logic             sda_bit_s;
    logic             in_bit_s, stretch_q_s, hold_s, tick_s, bit_end_s;
    logic             scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;

    // Pad drive for a given state/quarter; returns {scl_oe, sda_oe}.
    // bit_out is the level wanted on SDA during a data bit (1 = released).
    function automatic logic [1:0] pad_drive(input state_t st, input logic [1:0] q,
                                             input logic bit_out);
        logic scl_low;
        scl_low = (q == 2'd0) || (q == 2'd1);
        case (st)
            S_IDLE:             pad_drive = 2'b00;
            S_START: begin
                case (q)
                    2'd0, 2'd1: pad_drive = 2'b00;
                    2'd2:       pad_drive = 2'b01;
                    default:    pad_drive = 2'b11;
                endcase
            end
            S_ADDR, S_DATA:     pad_drive = {scl_low, ~bit_out};
            S_ADDR_ACK, S_DACK: pad_drive = {scl_low, 1'b0};
            S_STOP: begin
                case (q)
                    2'd0:       pad_drive = 2'b11;
                    2'd1, 2'd2: pad_drive = 2'b01;
                    default:    pad_drive = 2'b00;
                endcase
            end
            default:            pad_drive = 2'b00;
        endcase
    endfunction

    // Two-flop synchronisers for the pad levels; idle bus reads high.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Quarter tick generation, including the clock-stretch hold window.
    always_comb begin
        in_bit_s = (state_r == S_ADDR) || (state_r == S_ADDR_ACK) ||
                   (state_r == S_DATA) || (state_r == S_DACK);
        if (state_r == S_STOP) begin
            stretch_q_s = (q_r == 2'd1);
        end else begin
            stretch_q_s = in_bit_s && (q_r == 2'd2);
        end
        hold_s    = stretch_q_s && !scl_sync_r && (div_r == HOLD_AT);
        tick_s    = (div_r == DIV_LAST) && !hold_s;
        bit_end_s = tick_s && (q_r == 2'd3);
    end

    // Next-state, datapath and next pad drive.
    always_comb begin
        nxt_state_s    = state_r;
        nxt_bit_s      = bit_r;
        nxt_shift_s    = shift_r;
        nxt_rnw_s      = rnw_r;
        nxt_data_s     = data_r;
        nxt_rx_data_s  = rx_data_r;
        nxt_rx_valid_s = 1'b0;
        nxt_nack_s     = nack_r;
        nxt_ready_s    = ready_r;

        if (state_r == S_IDLE) begin
            nxt_div_s = '0;
            nxt_q_s   = 2'd0;
        end else if (hold_s) begin
            nxt_div_s = div_r;
            nxt_q_s   = q_r;
        end else if (tick_s) begin
            nxt_div_s = '0;
            nxt_q_s   = q_r + 2'd1;
        end else begin
            nxt_div_s = div_r + DIV_W'(1);
            nxt_q_s   = q_r;
        end

        case (state_r)
            S_IDLE: begin
                if (cmd.cmd_valid && ready_r) begin
                    nxt_state_s = S_START;
                    nxt_rnw_s   = cmd.cmd_rnw;
                    nxt_data_s  = cmd.cmd_data;
                    nxt_shift_s = {SLAVE_ADDR, cmd.cmd_rnw};
                    nxt_bit_s   = 3'd0;
                    nxt_nack_s  = 1'b0;
                    nxt_ready_s = 1'b0;
                end else begin
                    nxt_ready_s = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) nxt_state_s = S_ADDR;
                else           nxt_state_s = S_START;
            end
            S_ADDR, S_DATA: begin
                if (bit_end_s) begin
                    // Shift out the sent bit; in a read the sampled bit shifts in.
                    nxt_shift_s = {shift_r[6:0], sda_sync_r};
                    if (bit_r == 3'd7) begin
                        nxt_bit_s   = 3'd0;
                        nxt_state_s = (state_r == S_ADDR) ? S_ADDR_ACK : S_DACK;
                    end else begin
                        nxt_bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    nxt_bit_s = bit_r;
                end
            end
            S_ADDR_ACK: begin
                if (bit_end_s) begin
                    if (sda_sync_r) begin
                        nxt_nack_s  = 1'b1;
                        nxt_state_s = S_STOP;
                    end else begin
                        nxt_shift_s = data_r;
                        nxt_state_s = S_DATA;
                    end
                end else begin
                    nxt_state_s = S_ADDR_ACK;
                end
            end
            S_DACK: begin
                if (bit_end_s) begin
                    nxt_state_s = S_STOP;
                    if (rnw_r) begin
                        nxt_rx_data_s  = shift_r;
                        nxt_rx_valid_s = 1'b1;
                    end else if (sda_sync_r) begin
                        nxt_nack_s = 1'b1;
                    end else begin
                        nxt_nack_s = nack_r;
                    end
                end else begin
                    nxt_state_s = S_DACK;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    nxt_state_s = S_IDLE;
                    nxt_ready_s = 1'b1;
                end else begin
                    nxt_state_s = S_STOP;
                end
            end
            default: begin
                nxt_state_s = S_IDLE;
                nxt_ready_s = 1'b1;
            end
        endcase

        // A read keeps SDA released through its data bits.
        if ((nxt_state_s == S_DATA) && nxt_rnw_s) begin
            sda_bit_s = 1'b1;
        end else begin
            sda_bit_s = nxt_shift_s[7];
        end
        pad_s = pad_drive(nxt_state_s, nxt_q_s, sda_bit_s);
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r    <= S_IDLE;
            div_r      <= '0;
            q_r        <= 2'd0;
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            rnw_r      <= 1'b0;
            data_r     <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            nack_r     <= 1'b0;
            ready_r    <= 1'b1;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            div_r      <= nxt_div_s;
            q_r        <= nxt_q_s;
            bit_r      <= nxt_bit_s;
            shift_r    <= nxt_shift_s;
            rnw_r      <= nxt_rnw_s;
            data_r     <= nxt_data_s;
            rx_data_r  <= nxt_rx_data_s;
            rx_valid_r <= nxt_rx_valid_s;
            nack_r     <= nxt_nack_s;
            ready_r    <= nxt_ready_s;
            scl_oe_r   <= pad_s[1];
            sda_oe_r   <= pad_s[0];
        end
    end

    assign scl_oe        = scl_oe_r;
    assign sda_oe        = sda_oe_r;
    assign cmd.cmd_ready = ready_r;
    assign cmd.rx_data   = rx_data_r;
    assign cmd.rx_valid  = rx_valid_r;
    assign cmd.nack      = nack_r;
endmodule

// File: tb/tb_i2c_uart_host.sv
// Directed bench for i2c_uart_host: a table of single transfers against a
// behavioural I2C slave, plus hand-written stretch, back-to-back and reset cases.
module tb_i2c_uart_host;
    logic clk = 1'b0;
    logic res = 1'b0;
    logic scl_oe, sda_oe, scl_i, sda_i;
    logic slave_scl_low = 1'b0;
    logic slave_sda_low = 1'b0;

    i2c_uart_host_if bus();

    i2c_uart_host #(.CLK_DIV(4), .SLAVE_ADDR(7'h42)) dut (
        .clk    (clk),
        .res    (res),
        .cmd    (bus),
        .scl_oe (scl_oe),
        .sda_oe (sda_oe),
        .scl_i  (scl_i),
        .sda_i  (sda_i)
    );

    // Open-drain bus: wired-AND of master and slave pull-downs.
    assign scl_i = ~(scl_oe | slave_scl_low);
    assign sda_i = ~(sda_oe | slave_sda_low);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic       ack_en = 1'b1;
    logic       data_ack_en = 1'b1;
    logic [7:0] rdata = 8'h00;
    int         rises = 0;
    int         n_stop = 0;
    logic       in_frame = 1'b0;
    logic [7:0] addr_seen = 8'h00;
    logic [7:0] data_seen = 8'h00;
    logic       ack1 = 1'b0;
    logic       ack2 = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    always @(negedge clk) begin
        if (scl_p && scl_i && sda_p && !sda_i) begin
            in_frame      <= 1'b1;
            rises         <= 0;
            slave_sda_low <= 1'b0;
        end else if (scl_p && scl_i && !sda_p && sda_i) begin
            if (in_frame) n_stop <= n_stop + 1;
            in_frame      <= 1'b0;
            slave_sda_low <= 1'b0;
        end else if (in_frame && !scl_p && scl_i) begin
            if (rises < 8)       addr_seen <= {addr_seen[6:0], sda_i};
            else if (rises == 8) ack1 <= sda_i;
            else if (rises < 17) data_seen <= {data_seen[6:0], sda_i};
            else if (rises == 17) ack2 <= sda_i;
            rises <= rises + 1;
        end else if (in_frame && scl_p && !scl_i) begin
            if (rises == 8)
                slave_sda_low <= ack_en;
            else if (rises >= 9 && rises <= 16 && addr_seen[0] && ack_en)
                slave_sda_low <= ~rdata[16 - rises];
            else if (rises == 17 && !addr_seen[0] && ack_en)
                slave_sda_low <= data_ack_en;
            else
                slave_sda_low <= 1'b0;
        end
        scl_p <= scl_i;
        sda_p <= sda_i;
    end

    int rxv_cnt = 0;
    always @(negedge clk) if (bus.rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;

    // Clock stretch: slave grabs SCL during ADDR bit 3 q1 and holds it
    // stretch_len cycles past the point where the master releases it (q2).
    int t_acc = 0;
    int stretch_len = 0;
    always @(posedge clk) begin
        #2;
        if (stretch_len > 0 && cyc == t_acc + 70)
            slave_scl_low <= 1'b1;
        else if (stretch_len > 0 && cyc == t_acc + 72 + stretch_len)
            slave_scl_low <= 1'b0;
    end

    // Present one command, wait for acceptance and completion; lat = cycles
    // from the accepting edge to cmd_ready high again (-1 on timeout).
    task automatic do_xfer(input logic rnw, input logic [7:0] d, output int lat);
        int k;
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = rnw;
        bus.cmd_data  = d;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        t_acc = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = ~rnw;
        bus.cmd_data  = ~d;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 3000) begin @(posedge clk); #1; k++; end
        lat = (bus.cmd_ready === 1'b1) ? (cyc - t_acc) : -1;
    endtask

    typedef struct {
        logic       rnw;
        logic [7:0] wdata;
        logic       ack_en;
        logic       data_ack_en;
        logic [7:0] rdata;
        int         exp_lat;
        logic       exp_nack;
        int         exp_rxv;
        logic [7:0] exp_rx;
        logic [7:0] exp_addr;
        int         exp_rises;
        logic       exp_ack1;
        logic       exp_ack2;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        int rxv0;
        int stop0;
        int t0;
        int k;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 320, 1'b0, 0, 8'h00, 8'h84, 19, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 320, 1'b0, 1, 8'h3C, 8'h85, 19, 1'b0, 1'b1, 8'h3C};
        vecs[2] = '{1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 176, 1'b1, 0, 8'h3C, 8'h84, 10, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 176, 1'b1, 0, 8'h3C, 8'h85, 10, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 320, 1'b0, 0, 8'h3C, 8'h84, 19, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 320, 1'b1, 0, 8'h3C, 8'h84, 19, 1'b0, 1'b1, 8'h5A};
        vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 320, 1'b0, 1, 8'hFF, 8'h85, 19, 1'b0, 1'b1, 8'hFF};
        vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h81, 320, 1'b0, 1, 8'h81, 8'h85, 19, 1'b0, 1'b1, 8'h81};

        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = 1'b0;
        bus.cmd_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst scl_oe", 32'(scl_oe), 32'd0);
        check("rst sda_oe", 32'(sda_oe), 32'd0);
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst rx_data", 32'(bus.rx_data), 32'h00);
        check("rst nack", 32'(bus.nack), 32'd0);
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transfers
        for (int i = 0; i < 8; i++) begin
            ack_en      = vecs[i].ack_en;
            data_ack_en = vecs[i].data_ack_en;
            rdata       = vecs[i].rdata;
            rxv0        = rxv_cnt;
            stop0       = n_stop;
            do_xfer(vecs[i].rnw, vecs[i].wdata, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d nack", i), 32'(bus.nack), 32'(vecs[i].exp_nack));
            check($sformatf("v%0d rx_valid pulses", i), 32'(rxv_cnt - rxv0), 32'(vecs[i].exp_rxv));
            check($sformatf("v%0d rx_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d addr byte", i), 32'(addr_seen), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d scl rises", i), 32'(rises), 32'(vecs[i].exp_rises));
            check($sformatf("v%0d addr ack", i), 32'(ack1), 32'(vecs[i].exp_ack1));
            check($sformatf("v%0d stop count", i), 32'(n_stop - stop0), 32'd1);
            if (vecs[i].exp_rises == 19) begin
                check($sformatf("v%0d data byte", i), 32'(data_seen), 32'(vecs[i].exp_byte));
                check($sformatf("v%0d data ack", i), 32'(ack2), 32'(vecs[i].exp_ack2));
            end
        end

        // Clock stretch of 37 cycles in ADDR bit 3
        ack_en = 1'b1;
        data_ack_en = 1'b1;
        stretch_len = 37;
        do_xfer(1'b0, 8'hA5, lat);
        stretch_len = 0;
        check("stretch latency", 32'(lat), 32'd357);
        check("stretch addr", 32'(addr_seen), 32'h84);
        check("stretch data", 32'(data_seen), 32'hA5);
        check("stretch nack", 32'(bus.nack), 32'd0);

        // Back-to-back: address-NACKed write, then a second write with cmd_valid held
        ack_en = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = 1'b0;
        bus.cmd_data  = 8'h11;
        @(posedge clk); #1;
        t0 = cyc;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        check("b2b first latency", 32'(cyc - t0), 32'd176);
        check("b2b first nack", 32'(bus.nack), 32'd1);
        ack_en = 1'b1;
        bus.cmd_data = 8'h5A;
        @(posedge clk); #1;
        check("b2b second accepted", 32'(bus.cmd_ready), 32'd0);
        check("b2b nack cleared", 32'(bus.nack), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        t0 = cyc;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        check("b2b second latency", 32'(cyc - t0), 32'd320);
        check("b2b second data", 32'(data_seen), 32'h5A);
        check("b2b second nack", 32'(bus.nack), 32'd0);

        // A command pulsed while busy is not queued
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = 1'b0;
        bus.cmd_data  = 8'h33;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        repeat (5) @(posedge clk);
        #1;
        check("busy cmd not queued", 32'(bus.cmd_ready), 32'd1);

        // Reset during DATA bit 4
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = 1'b0;
        bus.cmd_data  = 8'hA5;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (230) @(posedge clk);
        #1;
        check("pre-reset scl_oe", 32'(scl_oe), 32'd1);
        res = 1'b0;
        @(posedge clk); #1;
        check("mid reset scl_oe", 32'(scl_oe), 32'd0);
        check("mid reset sda_oe", 32'(sda_oe), 32'd0);
        check("mid reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid reset rx_data", 32'(bus.rx_data), 32'h00);
        @(posedge clk); #1;
        res = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_xfer(1'b0, 8'hC3, lat);
        check("post reset latency", 32'(lat), 32'd320);
        check("post reset addr", 32'(addr_seen), 32'h84);
        check("post reset data", 32'(data_seen), 32'hC3);
        check("post reset nack", 32'(bus.nack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
